// File: rtl/host_mem_ctrl_if.sv
// ============================================================================
// host_mem_ctrl_if
// ----------------------------------------------------------------------------
// Purpose : Bundles the host stream links (load in, result out), the control
//           inputs (start, bases, lengths), the multi-core host port
//           (status, com_*, end_process) and the controller flags.
//
// Modports:
//   master : the controller side (host_mem_ctrl). Consumes start/bases/
//            lengths, the load stream, out_ready, com_data_out and
//            end_process. Drives in_ready, the result stream, status,
//            com_addr/com_data_in/com_wr_en, busy, done and timeout.
//   slave  : the environment side (host link + multi-core top), mirrored.
// ============================================================================
interface host_mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    // Control
    logic              start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W-1:0] load_len;
    logic [ADDR_W-1:0] res_base;
    logic [ADDR_W-1:0] res_len;

    // Load stream (host -> controller)
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    // Result stream (controller -> host)
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    // Multi-core host port
    logic [1:0]        status;
    logic [ADDR_W-1:0] com_addr;
    logic [DATA_W-1:0] com_data_in;
    logic              com_wr_en;
    logic [DATA_W-1:0] com_data_out;
    logic              end_process;

    // Controller flags
    logic              busy;
    logic              done;
    logic              timeout;

    modport master (
        input  start, load_base, load_len, res_base, res_len,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready,
        output status, com_addr, com_data_in, com_wr_en,
        input  com_data_out, end_process,
        output busy, done, timeout
    );

    modport slave (
        output start, load_base, load_len, res_base, res_len,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready,
        input  status, com_addr, com_data_in, com_wr_en,
        output com_data_out, end_process,
        input  busy, done, timeout
    );
endinterface

// File: rtl/host_mem_ctrl.sv
// ============================================================================
// host_mem_ctrl
// ----------------------------------------------------------------------------
// Purpose : Host-side initiator for the multi-core top's host port. On each
//           start it streams an image into shared data memory (LOAD), lets
//           the cores run until end_process is seen on two consecutive clocks
//           (RUN), then streams a result window back out one word at a time
//           (RD_ISSUE / RD_WAIT / RD_HOLD) and pulses done on return to IDLE.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   io_bus  host_mem_ctrl_if.master : start, load/res base+len, load stream
//           (in_valid/in_data/in_ready), result stream (out_valid/out_data/
//           out_ready), host port (status, com_addr, com_data_in, com_wr_en,
//           com_data_out, end_process), busy, done, timeout.
//
// Parameters:
//   DATA_W          word width of streams and memory data
//   ADDR_W          width of com_addr, bases and lengths
//   RD_LAT          cycles from com_addr valid to com_data_out valid (1..4)
//   TIMEOUT_CYCLES  RUN watchdog limit (only with the optional watchdog)
//
// Optional feature:
//   HOST_MEM_CTRL_TIMEOUT_EN - when defined, a 16-bit watchdog counts RUN
//   cycles; reaching TIMEOUT_CYCLES without a qualified end_process sets the
//   sticky timeout flag and skips the readout. When undefined, RUN waits
//   indefinitely and timeout is tied to 0.
// ============================================================================
module host_mem_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int RD_LAT         = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic            clk,
    input  logic            rst_n,
    host_mem_ctrl_if.master io_bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_RD_ISSUE = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_RD_HOLD  = 3'd5;
    localparam logic [2:0] S_FIN      = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_READ = 2'b11;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    // FSM and captured operation parameters
    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_load_base;
    logic [ADDR_W-1:0] r_load_len;
    logic [ADDR_W-1:0] r_res_base;
    logic [ADDR_W-1:0] r_res_len;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_ridx;
    logic [2:0]        r_lat;
    logic              r_ep_seen;

    // Registered outputs
    logic [1:0]        r_status;
    logic [ADDR_W-1:0] r_com_addr;
    logic [DATA_W-1:0] r_com_data_in;
    logic              r_com_wr_en;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_busy;
    logic              r_done;

`ifdef HOST_MEM_CTRL_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]       r_to_cnt;
    logic              r_timeout;
`endif

    logic              w_in_fire;
    logic              w_out_fire;
    logic [ADDR_W:0]   w_idx_next;
    logic [ADDR_W:0]   w_ridx_next;

    // Counters are extended by one bit so a length of all-ones still
    // compares correctly against the post-increment index.
    assign w_in_fire   = io_bus.in_valid & r_in_ready;
    assign w_out_fire  = r_out_valid & io_bus.out_ready;
    assign w_idx_next  = {1'b0, r_idx}  + (ADDR_W+1)'(1);
    assign w_ridx_next = {1'b0, r_ridx} + (ADDR_W+1)'(1);

    // Main controller. Every output is registered so the top sees clean,
    // glitch-free status and host-port signals. com_wr_en and done are
    // one-cycle strobes that default low each clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_load_base   <= '0;
            r_load_len    <= '0;
            r_res_base    <= '0;
            r_res_len     <= '0;
            r_idx         <= '0;
            r_ridx        <= '0;
            r_lat         <= '0;
            r_ep_seen     <= 1'b0;
            r_status      <= ST_IDLE;
            r_com_addr    <= '0;
            r_com_data_in <= '0;
            r_com_wr_en   <= 1'b0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
`ifdef HOST_MEM_CTRL_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_com_wr_en <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_load_base <= io_bus.load_base;
                        r_load_len  <= io_bus.load_len;
                        r_res_base  <= io_bus.res_base;
                        r_res_len   <= io_bus.res_len;
                        r_idx       <= '0;
                        r_ridx      <= '0;
                        r_ep_seen   <= 1'b0;
                        r_busy      <= 1'b1;
`ifdef HOST_MEM_CTRL_TIMEOUT_EN
                        r_to_cnt    <= '0;
                        r_timeout   <= 1'b0;
`endif
                        if (io_bus.load_len != '0) begin
                            r_state    <= S_LOAD;
                            r_status   <= ST_LOAD;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state  <= S_RUN;
                            r_status <= ST_RUN;
                        end
                    end
                end

                // in_ready falls on the edge that accepts the last word; the
                // cycle after, with in_ready low, is the final write strobe
                // and the FSM moves on to RUN at its end.
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_com_wr_en   <= 1'b1;
                        r_com_addr    <= r_load_base + r_idx;
                        r_com_data_in <= io_bus.in_data;
                        r_idx         <= r_idx + 1'b1;
                        if (w_idx_next == {1'b0, r_load_len}) begin
                            r_in_ready <= 1'b0;
                        end
                    end else if (!r_in_ready) begin
                        r_state   <= S_RUN;
                        r_status  <= ST_RUN;
                        r_ep_seen <= 1'b0;
`ifdef HOST_MEM_CTRL_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                    end
                end

                // end_process must be high on two consecutive clocks so the
                // short glitch when the cores are released does not end RUN.
                // The first read address is presented on entry to RD_ISSUE.
                S_RUN: begin
                    if (io_bus.end_process && r_ep_seen) begin
                        if (r_res_len != '0) begin
                            r_state    <= S_RD_ISSUE;
                            r_status   <= ST_READ;
                            r_com_addr <= r_res_base;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end else begin
                        r_ep_seen <= io_bus.end_process;
`ifdef HOST_MEM_CTRL_TIMEOUT_EN
                        if (r_to_cnt == TO_LAST) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_FIN;
                        end else begin
                            r_to_cnt <= r_to_cnt + 16'd1;
                        end
`endif
                    end
                end

                S_RD_ISSUE: begin
                    r_state <= S_RD_WAIT;
                    r_lat   <= 3'd1;
                end

                // The address has been stable since RD_ISSUE, so after
                // RD_LAT cycles the memory output belongs to it.
                S_RD_WAIT: begin
                    if (r_lat == LAT) begin
                        r_out_data  <= io_bus.com_data_out;
                        r_out_valid <= 1'b1;
                        r_state     <= S_RD_HOLD;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end

                S_RD_HOLD: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_ridx      <= r_ridx + 1'b1;
                        if (w_ridx_next < {1'b0, r_res_len}) begin
                            r_state    <= S_RD_ISSUE;
                            r_com_addr <= r_res_base + w_ridx_next[ADDR_W-1:0];
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end

                S_FIN: begin
                    r_done   <= 1'b1;
                    r_status <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_status    <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.in_ready    = r_in_ready;
    assign io_bus.out_valid   = r_out_valid;
    assign io_bus.out_data    = r_out_data;
    assign io_bus.status      = r_status;
    assign io_bus.com_addr    = r_com_addr;
    assign io_bus.com_data_in = r_com_data_in;
    assign io_bus.com_wr_en   = r_com_wr_en;
    assign io_bus.busy        = r_busy;
    assign io_bus.done        = r_done;
`ifdef HOST_MEM_CTRL_TIMEOUT_EN
    assign io_bus.timeout     = r_timeout;
`else
    assign io_bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_host_mem_ctrl.sv
// ============================================================================
// tb_host_mem_ctrl
// ----------------------------------------------------------------------------
// Bench for host_mem_ctrl: drives the load stream and end_process, models
// the shared data memory with RD_LAT read latency, and scoreboards every
// write strobe and every result beat against queued expectations.
// ============================================================================
module tb_host_mem_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int RD_LAT = 1;
    localparam int TO_CYC = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    host_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) hostIf ();

    host_mem_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_bus(hostIf)
    );

    always #5 clk = ~clk;

    // Shared memory model: unwritten locations return a fixed pattern
    bit [15:0] mem     [0:65535];
    bit        wrValid [0:65535];
    bit [15:0] rdPipe  [0:RD_LAT-1];

    function automatic logic [15:0] memRead(input logic [15:0] a);
        return wrValid[a] ? mem[a] : (a ^ 16'hA55A);
    endfunction

    always @(posedge clk) begin
        if (hostIf.com_wr_en) begin
            mem[hostIf.com_addr]     <= hostIf.com_data_in;
            wrValid[hostIf.com_addr] <= 1'b1;
        end
        rdPipe[0] <= memRead(hostIf.com_addr);
        for (int k = 1; k < RD_LAT; k++) rdPipe[k] <= rdPipe[k-1];
    end

    assign hostIf.com_data_out = rdPipe[RD_LAT-1];

    // Scoreboard state
    int          checks = 0;
    int          errors = 0;
    int          cycleCnt = 0;
    int          wrCount = 0;
    int          wrFirst = 0;
    int          wrLast = 0;
    int          doneCount = 0;
    int          doneCyc = 0;
    int          beatCyc[$];
    logic [31:0] wrQ[$];
    logic [15:0] rdQ[$];
    logic [15:0] loadAddr;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    always @(posedge clk) cycleCnt++;

    // Output monitor: pops the scoreboard on every write strobe and beat
    always @(negedge clk) begin
        if (rst_n) begin
            if (hostIf.com_wr_en) begin
                if (wrCount == 0) wrFirst = cycleCnt;
                wrLast = cycleCnt;
                wrCount++;
                if (wrQ.size() == 0) begin
                    checkOutput("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = wrQ.pop_front();
                    checkOutput("wr_addr", 32'(hostIf.com_addr), 32'(e[31:16]));
                    checkOutput("wr_data", 32'(hostIf.com_data_in), 32'(e[15:0]));
                end
            end
            if (hostIf.out_valid && hostIf.out_ready) begin
                beatCyc.push_back(cycleCnt);
                if (rdQ.size() == 0) begin
                    checkOutput("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    checkOutput("rd_data", 32'(hostIf.out_data), 32'(rdQ.pop_front()));
                end
            end
            if (hostIf.done) begin
                doneCount++;
                doneCyc = cycleCnt;
            end
        end
    end

    task automatic startOp(input logic [15:0] lb, input logic [15:0] ll,
                           input logic [15:0] rb, input logic [15:0] rl);
        @(posedge clk); #1;
        hostIf.load_base = lb;
        hostIf.load_len  = ll;
        hostIf.res_base  = rb;
        hostIf.res_len   = rl;
        hostIf.start     = 1'b1;
        loadAddr         = lb;
        @(posedge clk); #1;
        hostIf.start     = 1'b0;
    endtask

    // Offers one load word and waits (bounded) for it to be accepted
    task automatic applyStimulus(input logic [15:0] word);
        bit accepted = 1'b0;
        hostIf.in_valid = 1'b1;
        hostIf.in_data  = word;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge clk);
            if (hostIf.in_ready) begin
                wrQ.push_back({loadAddr, word});
                loadAddr = loadAddr + 16'd1;
                accepted = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!accepted) checkOutput("load_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pushReads(input logic [15:0] rb, input int rl);
        for (int i = 0; i < rl; i++) rdQ.push_back(memRead(rb + 16'(i)));
    endtask

    task automatic waitDone(input int limit, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (hostIf.done) seen = 1'b1;
        end
        if (!seen) checkOutput(tag, 32'd0, 32'd1);
    endtask

    task automatic waitOutValid(input int limit, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (hostIf.out_valid) seen = 1'b1;
        end
        if (!seen) checkOutput(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] held;
        hostIf.start       = 1'b0;
        hostIf.load_base   = '0;
        hostIf.load_len    = '0;
        hostIf.res_base    = '0;
        hostIf.res_len     = '0;
        hostIf.in_valid    = 1'b0;
        hostIf.in_data     = '0;
        hostIf.out_ready   = 1'b0;
        hostIf.end_process = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_status",    32'(hostIf.status), 32'd0);
        checkOutput("rst_wr_en",     32'(hostIf.com_wr_en), 32'd0);
        checkOutput("rst_com_addr",  32'(hostIf.com_addr), 32'd0);
        checkOutput("rst_com_data",  32'(hostIf.com_data_in), 32'd0);
        checkOutput("rst_in_ready",  32'(hostIf.in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(hostIf.out_valid), 32'd0);
        checkOutput("rst_out_data",  32'(hostIf.out_data), 32'd0);
        checkOutput("rst_busy",      32'(hostIf.busy), 32'd0);
        checkOutput("rst_done",      32'(hostIf.done), 32'd0);
        checkOutput("rst_timeout",   32'(hostIf.timeout), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a 5-word load, after 2 words
        startOp(16'h0200, 16'd5, 16'h0000, 16'd0);
        checkOutput("ml_status", 32'(hostIf.status), 32'd1);
        checkOutput("ml_busy",   32'(hostIf.busy), 32'd1);
        applyStimulus(16'h1111);
        applyStimulus(16'h2222);
        checkOutput("ml_wr_before_rst", 32'(hostIf.com_wr_en), 32'd1);
        hostIf.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("ml_rst_wr_en",    32'(hostIf.com_wr_en), 32'd0);
        checkOutput("ml_rst_status",   32'(hostIf.status), 32'd0);
        checkOutput("ml_rst_in_ready", 32'(hostIf.in_ready), 32'd0);
        checkOutput("ml_rst_busy",     32'(hostIf.busy), 32'd0);
        wrQ.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back-to-back load, glitch filter, wrapped readout with back-pressure
        wrCount = 0;
        doneCount = 0;
        beatCyc.delete();
        startOp(16'h0010, 16'd3, 16'hFFFF, 16'd2);
        applyStimulus(16'h00A1);
        applyStimulus(16'h00B2);
        applyStimulus(16'h00C3);
        hostIf.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("load_in_ready_low", 32'(hostIf.in_ready), 32'd0);
        checkOutput("load_status_last",  32'(hostIf.status), 32'd1);
        @(negedge clk);
        checkOutput("run_status",    32'(hostIf.status), 32'd2);
        checkOutput("load_wr_count", 32'(wrCount), 32'd3);
        checkOutput("load_wr_span",  32'(wrLast - wrFirst), 32'd2);

        @(posedge clk); #1;
        hostIf.end_process = 1'b1;
        @(posedge clk); #1;
        hostIf.end_process = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("glitch_ignored", 32'(hostIf.status), 32'd2);

        pushReads(16'hFFFF, 2);
        @(posedge clk); #1;
        hostIf.end_process = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("hold_edge1_status", 32'(hostIf.status), 32'd2);
        @(negedge clk);
        checkOutput("hold_edge2_status", 32'(hostIf.status), 32'd3);
        hostIf.end_process = 1'b0;

        waitOutValid(20, "rd_valid_timeout");
        held = hostIf.out_data;
        checkOutput("first_beat_data", 32'(held), 32'(16'hFFFF ^ 16'hA55A));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(hostIf.out_valid), 32'd1);
            checkOutput("stall_data",  32'(hostIf.out_data), 32'(held));
        end
        checkOutput("stall_no_beat", 32'(beatCyc.size()), 32'd0);
        @(posedge clk); #1;
        hostIf.out_ready = 1'b1;
        waitDone(40, "a_done_timeout");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("a_beats",      32'(beatCyc.size()), 32'd2);
        checkOutput("a_done_count", 32'(doneCount), 32'd1);
        checkOutput("a_done_after_beat", 32'(doneCyc > beatCyc[1]), 32'd1);
        checkOutput("a_rdq_empty",  32'(rdQ.size()), 32'd0);
        checkOutput("a_status_idle", 32'(hostIf.status), 32'd0);
        checkOutput("a_busy_low",   32'(hostIf.busy), 32'd0);

        // Load with a gap, then read back across the written region
        wrCount = 0;
        doneCount = 0;
        beatCyc.delete();
        startOp(16'h0100, 16'd2, 16'h00FF, 16'd4);
        applyStimulus(16'h1234);
        hostIf.in_valid = 1'b0;
        @(posedge clk); #1;
        applyStimulus(16'h5678);
        hostIf.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("e_status_run", 32'(hostIf.status), 32'd2);
        pushReads(16'h00FF, 4);
        checkOutput("e_expect_written", 32'(rdQ[1]), 32'h1234);
        hostIf.end_process = 1'b1;
        waitDone(80, "e_done_timeout");
        hostIf.end_process = 1'b0;
        @(posedge clk); #1;
        checkOutput("e_wr_count", 32'(wrCount), 32'd2);
        checkOutput("e_beats",    32'(beatCyc.size()), 32'd4);
        if (beatCyc.size() == 4) begin
            checkOutput("e_rate_01", 32'(beatCyc[1] - beatCyc[0]), 32'(RD_LAT + 2));
            checkOutput("e_rate_23", 32'(beatCyc[3] - beatCyc[2]), 32'(RD_LAT + 2));
        end

        // Zero lengths with end_process already high
        wrCount = 0;
        doneCount = 0;
        beatCyc.delete();
        hostIf.end_process = 1'b1;
        startOp(16'h0000, 16'd0, 16'h0000, 16'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("z_done_%0d", k), 32'(hostIf.done), (k == 3) ? 32'd1 : 32'd0);
            if (k == 0) checkOutput("z_status_run", 32'(hostIf.status), 32'd2);
        end
        hostIf.end_process = 1'b0;
        checkOutput("z_no_writes", 32'(wrCount), 32'd0);
        checkOutput("z_no_beats",  32'(beatCyc.size()), 32'd0);

`ifdef HOST_MEM_CTRL_TIMEOUT_EN
        // Watchdog: no end_process, readout must be skipped
        begin
            int c0;
            doneCount = 0;
            beatCyc.delete();
            startOp(16'h0000, 16'd0, 16'h0000, 16'd2);
            c0 = cycleCnt;
            waitDone(TO_CYC + 10, "to_done_timeout");
            checkOutput("to_flag", 32'(hostIf.timeout), 32'd1);
            checkOutput("to_latency_ok",
                        32'((doneCyc - c0 >= TO_CYC) && (doneCyc - c0 <= TO_CYC + 2)), 32'd1);
            checkOutput("to_no_beats", 32'(beatCyc.size()), 32'd0);
            hostIf.end_process = 1'b1;
            startOp(16'h0000, 16'd0, 16'h0000, 16'd0);
            checkOutput("to_cleared", 32'(hostIf.timeout), 32'd0);
            waitDone(20, "to_next_done_timeout");
            hostIf.end_process = 1'b0;
        end
`else
        checkOutput("timeout_tied_low", 32'(hostIf.timeout), 32'd0);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
